sawtooth_wave_gen: RTL and testbench
====================================

// Module: sawtooth_wave_gen
// PURPOSE
//  Parametrised, streaming successor to the per-duty sawtooth lookup tables.
//  A phase accumulator generates the ramp. The shape is computed from per-select slope constants, so no memory files are needed.
//  The rise fraction is selectable in 10% steps: 10 = rising sawtooth, 5 = symmetric triangle.
//  Configuration is double-buffered and applied only at period boundaries (glitch-free).
//  Feeds the DAC/output mux of the wave generator.
// PARAMETERS
//  PHASE_W  24  phase accumulator width
//  ADDR_W   10  phase bits used for shaping (N = 2**ADDR_W points/period)
//  DATA_W   16  output sample width (MAX = 2**DATA_W-1)
//  FRAC_W   16  fractional bits of slope constants
// PORTS
//  i_clk     in   1        clock
//  i_rst_n   in   1        async active-low reset
//  i_en      in   1        advance phase / produce samples
//  i_sync    in   1        sync phase clear (multi-channel alignment)
//  i_load    in   1        pulse: capture i_fcw/i_sel into pending config
//  i_fcw     in   PHASE_W  frequency control word (phase step)
//  i_sel     in   4        rise fraction: 0 = off, 1..10 = 10%..100%, 11..15 illegal
//  o_data    out  DATA_W   sample
//  o_valid   out  1        o_data is a new sample this cycle
//  o_wrap    out  1        o_data is the first sample of a period
//  o_pending out  1        loaded config not yet applied
// BEHAVIOUR
//  Reset (async, all outputs/state):
//   acc = 0; active fcw/sel = 0; pending = 0.
//   o_data = 0, o_valid = 0, o_wrap = 0, o_pending = 0.
//  Phase:
//   - When i_en = 1: acc <= acc + fcw_act, mod 2**PHASE_W.
//   - wrap = carry-out of that add.
//   - When i_en = 0: acc holds.
//  Sample index: p = acc[PHASE_W-1 -: ADDR_W].
//  Shape for active sel s in 1..10:
//   - L = floor(s*N/10), D = N-L.
//   - RUP = floor(MAX*2**FRAC_W/L); RDN = floor(MAX*2**FRAC_W/D), with RDN unused when D = 0.
//   - Slope constants are computed at elaboration by a function (no runtime divide).
//   - p < L : y = (p*RUP) >> FRAC_W.
//   - p >= L: y = ((N-p)*RDN) >> FRAC_W.
//   - y is saturated to MAX; the product width is ADDR_W+DATA_W+FRAC_W, with no truncation before the shift.
//   - s = 0 or illegal: y = 0.
//  Pipeline:
//   - Stage 1 registers segment select and product; stage 2 saturates and registers o_data.
//   - The sample for acc value A appears on o_data 2 cycles after A is in acc.
//   - o_valid = i_en delayed 2; o_wrap = wrap-of-that-sample delayed 2.
//   - When o_valid = 0, o_data holds its last value.
//  Config buffer:
//   - i_load sets pending <= {i_fcw, i_sel}, o_pending <= 1.
//   - A second i_load before apply overwrites pending (last wins).
//   - Pending is applied (act <= pending, o_pending <= 0) on the first of: wrap, i_sync, or active sel = 0.
//   - i_load in the same cycle as an apply: the i_load values are applied directly; o_pending stays 0.
//   - Illegal i_sel is stored as 0.
//  Sync:
//   - i_sync = 1 clears acc to 0 next cycle and applies pending.
//   - i_sync has priority over the add and over wrap.
//   - The next sample carries o_wrap = 1.
//  Reset mid-operation: everything returns to reset values immediately; pending config is lost.
// TESTING (ADDR_W=10, PHASE_W=24, DATA_W=16, FRAC_W=16)
//  1. Load sel=10, fcw=2**14 (p +1/cycle), en=1.
//     -> o_data: p=1 -> 63; p=1023 -> 65471; p=0 with o_wrap=1 -> 0.
//     -> Latency exactly 2 cycles.
//  2. sel=5, same fcw -> p=511 -> 65407; p=512 -> 65535 (peak); p=1023 -> 127.
//  3. Running sel=10; at p=300 load sel=5, fcw=2**15.
//     -> o_pending=1 until wrap; old shape until o_wrap, new shape/step after.
//  4. Load sel=12 -> o_data=0 with o_valid=1.
//     Then i_sync plus load sel=10 -> next o_data=0, o_wrap=1, ramp restarts.
//  5. i_en low for 5 cycles mid-ramp -> o_valid low 2 cycles later, o_data frozen.
//     On resume, the sequence continues from the held p.
//  6. Assert i_rst_n=0 asynchronously mid-period (between clock edges)
//     -> o_data=0, o_valid=0, o_pending=0 at once.
//     After release, no output until a new i_load.

Source files
------------

// File: rtl/sawtooth_wave_gen.sv
// sawtooth_wave_gen: phase-accumulator sawtooth/triangle generator with
// elaboration-time slope tables and config applied only at period boundaries.
module sawtooth_wave_gen #(
    parameter int PHASE_W = 24,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 16,
    parameter int FRAC_W  = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_en,
    input  logic               i_sync,
    input  logic               i_load,
    input  logic [PHASE_W-1:0] i_fcw,
    input  logic [3:0]         i_sel,
    output logic [DATA_W-1:0]  o_data,
    output logic               o_valid,
    output logic               o_wrap,
    output logic               o_pending
);
    localparam int N  = 2**ADDR_W;
    localparam int SW = DATA_W + FRAC_W;
    localparam int LW = ADDR_W + 1;
    localparam int PW = ADDR_W + DATA_W + FRAC_W;
    localparam logic [DATA_W-1:0] MAX = '1;

    function automatic longint lim(input int s);
        return longint'(s) * N / 10;
    endfunction

    function automatic logic [11*SW-1:0] slopes(input logic up);
        logic [11*SW-1:0] t;
        longint c;
        t = '0;
        for (int s = 1; s <= 10; s++) begin
            c = up ? lim(s) : longint'(N) - lim(s);
            if (c != 0) t[s*SW +: SW] = SW'((longint'(MAX) << FRAC_W) / c);
        end
        return t;
    endfunction

    function automatic logic [11*LW-1:0] lens();
        logic [11*LW-1:0] t;
        t = '0;
        for (int s = 1; s <= 10; s++) t[s*LW +: LW] = LW'(lim(s));
        return t;
    endfunction

    localparam logic [11*SW-1:0] RUP_T = slopes(1'b1);
    localparam logic [11*SW-1:0] RDN_T = slopes(1'b0);
    localparam logic [11*LW-1:0] LEN_T = lens();

    typedef enum logic [1:0] {SEG_UP, SEG_DN, SEG_OFF} seg_t;

    logic [PHASE_W-1:0] acc, fcw_act, pend_fcw;
    logic [3:0]         sel_act, pend_sel, sel_in;
    logic               wrap_q, apply, s1_valid, s1_wrap;
    logic [PHASE_W:0]   sum;
    logic [ADDR_W-1:0]  p;
    logic [LW-1:0]      len;
    seg_t               seg, s1_seg;
    logic [PW-1:0]      prod, s1_prod;
    logic [PW-FRAC_W-1:0] shifted;
    logic [DATA_W-1:0]  sat;

    always_comb begin
        sum     = {1'b0, acc} + {1'b0, fcw_act};
        apply   = (i_en & sum[PHASE_W]) | i_sync | (sel_act == '0);
        sel_in  = i_sel > 4'd10 ? 4'd0 : i_sel;
        p       = acc[PHASE_W-1 -: ADDR_W];
        len     = LEN_T[int'(sel_act)*LW +: LW];
        seg     = sel_act == '0 ? SEG_OFF : ({1'b0, p} < len ? SEG_UP : SEG_DN);
        prod    = seg == SEG_UP ? PW'(p) * PW'(RUP_T[int'(sel_act)*SW +: SW])
                                : PW'(N - int'(p)) * PW'(RDN_T[int'(sel_act)*SW +: SW]);
        shifted = s1_prod[PW-1:FRAC_W];
        sat     = |shifted[PW-FRAC_W-1:DATA_W] ? MAX : shifted[DATA_W-1:0];
    end

    // sync outranks both the phase add and wrap; its next sample is a period start
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc       <= '0;
            wrap_q    <= 1'b0;
            fcw_act   <= '0;
            sel_act   <= '0;
            pend_fcw  <= '0;
            pend_sel  <= '0;
            o_pending <= 1'b0;
            s1_seg    <= SEG_OFF;
            s1_prod   <= '0;
            s1_valid  <= 1'b0;
            s1_wrap   <= 1'b0;
            o_data    <= '0;
            o_valid   <= 1'b0;
            o_wrap    <= 1'b0;
        end else begin
            if (i_sync) begin
                acc    <= '0;
                wrap_q <= 1'b1;
            end else if (i_en) begin
                acc    <= sum[PHASE_W-1:0];
                wrap_q <= sum[PHASE_W];
            end
            if (i_load && apply) begin
                fcw_act   <= i_fcw;
                sel_act   <= sel_in;
                o_pending <= 1'b0;
            end else if (i_load) begin
                pend_fcw  <= i_fcw;
                pend_sel  <= sel_in;
                o_pending <= 1'b1;
            end else if (o_pending && apply) begin
                fcw_act   <= pend_fcw;
                sel_act   <= pend_sel;
                o_pending <= 1'b0;
            end
            s1_seg   <= seg;
            s1_prod  <= prod;
            s1_valid <= i_en;
            s1_wrap  <= i_en & wrap_q;
            if (s1_valid) o_data <= s1_seg == SEG_OFF ? '0 : sat;
            o_valid  <= s1_valid;
            o_wrap   <= s1_wrap;
        end
    end
endmodule

// File: tb/tb_sawtooth_wave_gen.sv
// tb_sawtooth_wave_gen: directed stimulus checked every cycle against a spec-level model.
module tb_sawtooth_wave_gen;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0, sync = 1'b0, load = 1'b0;
    logic [23:0] fcw = '0;
    logic [3:0]  sel = '0;
    logic [15:0] data;
    logic        valid, wrap, pending;
    int          errors = 0, checks = 0;

    sawtooth_wave_gen dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_sync(sync), .i_load(load),
        .i_fcw(fcw), .i_sel(sel), .o_data(data), .o_valid(valid), .o_wrap(wrap),
        .o_pending(pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic longint shape(input int p, input int s);
        longint l, y;
        if (s == 0 || s > 10) return 0;
        l = longint'(s) * 1024 / 10;
        if (p < l) y = (longint'(p) * ((longint'(65535) << 16) / l)) >> 16;
        else       y = (longint'(1024 - p) * ((longint'(65535) << 16) / (1024 - l))) >> 16;
        return y > 65535 ? 65535 : y;
    endfunction

    logic [23:0] m_acc, m_fcw, m_pfcw;
    logic [3:0]  m_sel, m_psel;
    logic        m_pend, m_wf, e1_v, e1_w, exp_v, exp_w;
    logic [15:0] e1_d, exp_d;

    always @(posedge clk or negedge rst_n) begin : model
        logic [24:0] s;
        logic        cy, ap;
        logic [3:0]  ls;
        if (!rst_n) begin
            m_acc <= '0; m_fcw <= '0; m_pfcw <= '0; m_sel <= '0; m_psel <= '0;
            m_pend <= 1'b0; m_wf <= 1'b0; e1_v <= 1'b0; e1_w <= 1'b0; e1_d <= '0;
            exp_v <= 1'b0; exp_w <= 1'b0; exp_d <= '0;
        end else begin
            s  = {1'b0, m_acc} + {1'b0, m_fcw};
            cy = en && s[24];
            ap = cy || sync || m_sel == 0;
            ls = sel > 10 ? 4'd0 : sel;
            if (sync) begin
                m_acc <= '0; m_wf <= 1'b1;
            end else if (en) begin
                m_acc <= s[23:0]; m_wf <= cy;
            end
            e1_v  <= en;
            e1_w  <= en && m_wf;
            e1_d  <= 16'(shape(int'(m_acc[23:14]), int'(m_sel)));
            exp_v <= e1_v;
            exp_w <= e1_w;
            if (e1_v) exp_d <= e1_d;
            if (load && ap) begin
                m_fcw <= fcw; m_sel <= ls; m_pend <= 1'b0;
            end else if (load) begin
                m_pfcw <= fcw; m_psel <= ls; m_pend <= 1'b1;
            end else if (m_pend && ap) begin
                m_fcw <= m_pfcw; m_sel <= m_psel; m_pend <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        chk("data", data, exp_d);
        chk("valid", valid, exp_v);
        chk("wrap", wrap, exp_w);
        chk("pending", pending, m_pend);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_wrap(input string nm, input int limit);
        int n = 0;
        while (!wrap && n < limit) begin
            step(1);
            n++;
        end
        chk(nm, wrap, 1);
    endtask

    task automatic do_load(input logic [3:0] s, input logic [23:0] f, input logic sy);
        sel = s; fcw = f; load = 1'b1; sync = sy;
        step(1);
        load = 1'b0; sync = 1'b0;
    endtask

    initial begin
        logic [15:0] held;
        chk("model_s10_p1", shape(1, 10), 63);
        chk("model_s10_p1023", shape(1023, 10), 65471);
        chk("model_s5_p511", shape(511, 5), 65407);
        chk("model_s5_p512", shape(512, 5), 65535);
        chk("model_s5_p1023", shape(1023, 5), 127);
        #1 rst_n = 1'b0;
        #22 rst_n = 1'b1;
        chk("rst_data", data, 0);
        chk("rst_valid", valid, 0);
        chk("rst_pending", pending, 0);
        step(2);
        // 1: rising ramp, latency 2
        do_load(4'd10, 24'h004000, 1'b0);
        chk("t1_pending", pending, 0);
        en = 1'b1;
        step(1);
        chk("t1_lat_valid0", valid, 0);
        step(1);
        chk("t1_lat_valid1", valid, 1);
        chk("t1_p0", data, 0);
        step(1);
        chk("t1_p1", data, 63);
        step(1022);
        chk("t1_p1023", data, 65471);
        chk("t1_p1023_wrap", wrap, 0);
        step(1);
        chk("t1_wrap", wrap, 1);
        chk("t1_wrap_data", data, 0);
        // 2: triangle
        do_load(4'd5, 24'h004000, 1'b1);
        step(2);
        chk("t2_sync_wrap", wrap, 1);
        chk("t2_p0", data, 0);
        step(511);
        chk("t2_p511", data, 65407);
        step(1);
        chk("t2_p512", data, 65535);
        step(511);
        chk("t2_p1023", data, 127);
        // 3: reconfigure mid-period
        do_load(4'd10, 24'h004000, 1'b1);
        step(300);
        do_load(4'd5, 24'h008000, 1'b0);
        chk("t3_pending", pending, 1);
        wait_wrap("t3_wrap_seen", 1100);
        chk("t3_pending_clear", pending, 0);
        step(1);
        chk("t3_new_shape", data, 255);
        // 4: illegal select then sync restart
        do_load(4'd12, 24'h004000, 1'b0);
        chk("t4_pending", pending, 1);
        wait_wrap("t4_wrap_seen", 600);
        step(3);
        chk("t4_off_data", data, 0);
        chk("t4_off_valid", valid, 1);
        do_load(4'd10, 24'h004000, 1'b1);
        step(2);
        chk("t4_sync_wrap", wrap, 1);
        chk("t4_sync_data", data, 0);
        step(1);
        chk("t4_restart", data, 63);
        // 5: enable gap
        step(100);
        en = 1'b0;
        step(1);
        chk("t5_valid_still", valid, 1);
        step(1);
        chk("t5_valid_low", valid, 0);
        held = data;
        step(3);
        chk("t5_held", data, held);
        en = 1'b1;
        step(2);
        chk("t5_resume", valid, 1);
        step(20);
        // 6: asynchronous reset mid-period
        do_load(4'd5, 24'h004000, 1'b0);
        chk("t6_pending", pending, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_rst_data", data, 0);
        chk("t6_rst_valid", valid, 0);
        chk("t6_rst_pending", pending, 0);
        @(posedge clk);
        #5 rst_n = 1'b1;
        step(10);
        chk("t6_no_output", data, 0);
        do_load(4'd10, 24'h004000, 1'b0);
        step(3);
        chk("t6_reload", data, 63);
        step(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
